// File: rtl/uart_tx_arbiter.sv
// Four-requester round-robin arbiter feeding one UART transmitter.
// It supports a lock that holds the grant for multi-byte bursts, and a watchdog that aborts stalled frames.
//   state     | meaning
//   IDLE      | arbitrate, or wait for the locked owner
//   LAUNCH    | ready is high; if the owner is still valid, strobe the byte
//   WAIT_DONE | transmitter busy, watchdog running
//   DRAIN     | let a stretched done flag fall before re-arbitrating
module uart_tx_arbiter #(
    parameter int TIMEOUT_CLKS = 16384
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic [3:0]  i_Req_Valid,
    input  logic [31:0] i_Req_Byte,
    input  logic [3:0]  i_Req_Lock,
    output logic [3:0]  o_Req_Ready,
    output logic [1:0]  o_Grant_Id,
    output logic        o_Tx_DV,
    output logic [7:0]  o_Tx_Byte,
    input  logic        i_Tx_Done,
    output logic        o_Busy,
    output logic        o_Timeout
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        DRAIN     = 2'd3
    } state_t;

    state_t      state, next_state;
    logic [1:0]  last_grant;
    logic        lock_held;
    logic [7:0]  byte_q;
    logic [15:0] wd;

    logic        found;
    logic [1:0]  pick;
    logic [1:0]  idx;
    logic        take;
    logic        accept;
    logic        timeout_hit;

    always_comb begin
        found = 1'b0;
        pick  = o_Grant_Id;
        idx   = 2'd0;
        if (lock_held) begin
            found = i_Req_Valid[o_Grant_Id];
        end else begin
            for (int k = 1; k <= 4; k++) begin
                idx = last_grant + 2'(k);
                if (!found && i_Req_Valid[idx]) begin
                    found = 1'b1;
                    pick  = idx;
                end
            end
        end
    end

    assign take        = (state == IDLE) && found;
    // The owner may withdraw while ready is up; that cancels the byte.
    assign accept      = (state == LAUNCH) && i_Req_Valid[o_Grant_Id];
    assign timeout_hit = (state == WAIT_DONE) && !i_Tx_Done
                         && (wd == 16'(TIMEOUT_CLKS - 1));

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:      next_state = take ? LAUNCH : IDLE;
            LAUNCH:    next_state = accept ? WAIT_DONE : IDLE;
            WAIT_DONE: begin
                if (i_Tx_Done)        next_state = DRAIN;
                else if (timeout_hit) next_state = IDLE;
                else                  next_state = WAIT_DONE;
            end
            DRAIN:     next_state = i_Tx_Done ? DRAIN : IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) state <= IDLE;
        else         state <= next_state;
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            o_Req_Ready <= 4'd0;
            o_Grant_Id  <= 2'd0;
            o_Tx_DV     <= 1'b0;
            o_Tx_Byte   <= 8'h00;
            o_Timeout   <= 1'b0;
            last_grant  <= 2'd3;
            lock_held   <= 1'b0;
            byte_q      <= 8'h00;
            wd          <= 16'd0;
        end else begin
            o_Req_Ready <= take ? (4'b0001 << pick) : 4'd0;
            o_Tx_DV     <= accept;
            o_Timeout   <= timeout_hit;
            if (take) begin
                o_Grant_Id <= pick;
                last_grant <= pick;
                byte_q     <= i_Req_Byte[{pick, 3'b000} +: 8];
                lock_held  <= i_Req_Lock[pick];
            end
            if (accept) o_Tx_Byte <= byte_q;
            if ((state == LAUNCH && !accept) || timeout_hit) lock_held <= 1'b0;
            if (state == LAUNCH)
                wd <= 16'd0;
            else if (state == WAIT_DONE && !i_Tx_Done && !timeout_hit)
                wd <= wd + 16'd1;
        end
    end

    assign o_Busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single request, round-robin, lock, cancel,
// watchdog, stretched done and mid-frame reset, with hand-computed expectations.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  valid = 4'd0;
    logic [31:0] req_byte = 32'd0;
    logic [3:0]  lock = 4'd0;
    logic [3:0]  ready;
    logic [1:0]  grant_id;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_done = 1'b0;
    logic        busy;
    logic        timeout;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_arbiter #(.TIMEOUT_CLKS(20)) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Req_Valid (valid),
        .i_Req_Byte  (req_byte),
        .i_Req_Lock  (lock),
        .o_Req_Ready (ready),
        .o_Grant_Id  (grant_id),
        .o_Tx_DV     (tx_dv),
        .o_Tx_Byte   (tx_byte),
        .i_Tx_Done   (tx_done),
        .o_Busy      (busy),
        .o_Timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid = 4'd0;
        lock = 4'd0;
        tx_done = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Wait for a ready pulse, check grant, then check the launch strobe one cycle later.
    task automatic grab(input logic [1:0] id, input logic [7:0] b, input bit keep, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ready != 4'd0) begin
                seen = 1'b1;
                break;
            end
        end
        chk_vec({tag, "_seen"}, 32'(seen), 32'd1);
        chk_vec({tag, "_rdy"}, 32'(ready), 32'(4'b0001 << id));
        chk_vec({tag, "_gnt"}, 32'(grant_id), 32'(id));
        tick();
        if (!keep) valid[id] = 1'b0;
        chk_vec({tag, "_dv"}, 32'(tx_dv), 32'd1);
        chk_vec({tag, "_byte"}, 32'(tx_byte), 32'(b));
        chk_vec({tag, "_rdy0"}, 32'(ready), 32'd0);
    endtask

    task automatic finish_tx(input int n_hi, input string tag);
        tx_done = 1'b1;
        repeat (n_hi) tick();
        tx_done = 1'b0;
        chk_vec({tag, "_drain"}, 32'(busy), 32'd1);
        tick();
        chk_vec({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int  n;
        bit  hit;
        bit  dv_seen;

        repeat (2) tick();
        chk_vec("rst_ready", 32'(ready), 32'd0);
        chk_vec("rst_dv", 32'(tx_dv), 32'd0);
        chk_vec("rst_byte", 32'(tx_byte), 32'd0);
        chk_vec("rst_grant", 32'(grant_id), 32'd0);
        chk_vec("rst_busy", 32'(busy), 32'd0);
        chk_vec("rst_timeout", 32'(timeout), 32'd0);
        rst = 1'b0;

        // single requester
        req_byte[23:16] = 8'hA5;
        valid = 4'b0100;
        grab(2'd2, 8'hA5, 1'b0, "single");
        chk_vec("single_busy", 32'(busy), 32'd1);
        tick();
        chk_vec("single_dv_pulse", 32'(tx_dv), 32'd0);
        finish_tx(1, "single");
        chk_vec("single_hold", 32'(tx_byte), 32'hA5);

        // round-robin from reset priority
        do_reset();
        req_byte = 32'hC3C2C1C0;
        valid = 4'b1111;
        grab(2'd0, 8'hC0, 1'b1, "rr0");  finish_tx(1, "rr0");
        grab(2'd1, 8'hC1, 1'b1, "rr1");  finish_tx(1, "rr1");
        grab(2'd2, 8'hC2, 1'b1, "rr2");  finish_tx(1, "rr2");
        grab(2'd3, 8'hC3, 1'b1, "rr3");  finish_tx(1, "rr3");
        grab(2'd0, 8'hC0, 1'b1, "rr4");
        valid = 4'd0;
        finish_tx(1, "rr4");

        // lock burst from requester 1 while requester 0 waits
        do_reset();
        req_byte[15:8] = 8'h10;
        lock = 4'b0010;
        valid = 4'b0010;
        grab(2'd1, 8'h10, 1'b1, "lk0");
        req_byte[15:8] = 8'h11;
        req_byte[7:0]  = 8'h55;
        valid = 4'b0011;
        finish_tx(1, "lk0");
        grab(2'd1, 8'h11, 1'b1, "lk1");
        req_byte[15:8] = 8'h12;
        lock = 4'b0000;
        finish_tx(1, "lk1");
        grab(2'd1, 8'h12, 1'b0, "lk2");
        finish_tx(1, "lk2");
        grab(2'd0, 8'h55, 1'b0, "lk3");
        finish_tx(1, "lk3");

        // requester withdraws while ready is up: nothing is sent
        do_reset();
        req_byte[15:8] = 8'hEE;
        valid = 4'b0010;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ready != 4'd0) begin
                hit = 1'b1;
                break;
            end
        end
        chk_vec("cx_seen", 32'(hit), 32'd1);
        valid = 4'd0;
        tick();
        chk_vec("cx_idle", 32'(busy), 32'd0);
        dv_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (tx_dv) dv_seen = 1'b1;
            tick();
        end
        chk_vec("cx_no_dv", 32'(dv_seen), 32'd0);

        // watchdog abort also drops a held lock
        do_reset();
        req_byte[31:24] = 8'h3C;
        lock = 4'b1000;
        valid = 4'b1000;
        grab(2'd3, 8'h3C, 1'b0, "to");
        lock = 4'd0;
        n = 0;
        hit = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (timeout) begin
                n = i;
                hit = 1'b1;
                break;
            end
        end
        chk_vec("to_seen", 32'(hit), 32'd1);
        chk_vec("to_cycles", 32'(n), 32'd20);
        chk_vec("to_busy", 32'(busy), 32'd0);
        tick();
        chk_vec("to_pulse", 32'(timeout), 32'd0);
        req_byte[7:0] = 8'h01;
        valid = 4'b0001;
        grab(2'd0, 8'h01, 1'b0, "to_unlock");
        finish_tx(1, "to_unlock");

        // stretched done must clear before the next launch
        do_reset();
        req_byte[31:24] = 8'h77;
        valid = 4'b1000;
        grab(2'd3, 8'h77, 1'b1, "st");
        req_byte[31:24] = 8'h78;
        tx_done = 1'b1;
        repeat (2) tick();
        tx_done = 1'b0;
        n = 0;
        hit = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (tx_dv) begin
                n = i;
                hit = 1'b1;
                break;
            end
        end
        chk_vec("st_seen", 32'(hit), 32'd1);
        chk_vec("st_gap_min", 32'(n >= 2), 32'd1);
        chk_vec("st_gap_max", 32'(n <= 4), 32'd1);
        chk_vec("st_byte", 32'(tx_byte), 32'h78);
        valid = 4'd0;
        finish_tx(1, "st2");

        // asynchronous reset mid-frame
        do_reset();
        req_byte[7:0] = 8'h42;
        valid = 4'b0001;
        grab(2'd0, 8'h42, 1'b0, "ar");
        req_byte[31:24] = 8'h99;
        valid = 4'b1000;
        #2;
        rst = 1'b1;
        #1;
        chk_vec("ar_busy", 32'(busy), 32'd0);
        chk_vec("ar_grant", 32'(grant_id), 32'd0);
        chk_vec("ar_byte", 32'(tx_byte), 32'd0);
        chk_vec("ar_dv", 32'(tx_dv), 32'd0);
        tick();
        rst = 1'b0;
        grab(2'd3, 8'h99, 1'b0, "ar_after");
        finish_tx(1, "ar_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT_CLKS, default 16384, is the maximum clocks from o_Tx_DV to i_Tx_Done before abort; legal range 2..65535.
REQ-002 i_Clock  in  1  single clock; all logic on its rising edge.
REQ-003 i_Reset  in  1  reset, asynchronous and active-high.
REQ-004 i_Req_Valid  in  4  per-requester byte-valid; bit n belongs to requester n.
REQ-005 i_Req_Byte  in  32  packed bytes; requester n uses bits [8n+7:8n].
REQ-006 i_Req_Lock  in  4  per-requester "more bytes follow, keep grant".
REQ-007 o_Req_Ready  out  4  one-hot accept strobe; a transfer occurs when valid and ready are both 1.
REQ-008 o_Grant_Id  out  2  index of the requester that currently owns the transmitter.
REQ-009 o_Tx_DV  out  1  start strobe to the UART transmitter.
REQ-010 o_Tx_Byte  out  8  byte to the UART transmitter.
REQ-011 i_Tx_Done  in  1  transmitter completion flag; may stay high for up to 2 consecutive cycles.
REQ-012 o_Busy  out  1  high in every state except IDLE.
REQ-013 o_Timeout  out  1  one-cycle pulse on a watchdog abort.

Function
REQ-014 The state machine SHALL have the states IDLE, LAUNCH, WAIT_DONE and DRAIN, and any illegal encoding SHALL go to IDLE next cycle.
REQ-015 IDLE with no lock held and any valid bit set SHALL grant round-robin.
- Search order: last_grant+1, +2, +3, +4 (mod 4).
- Actions in that cycle: o_Req_Ready[g]=1, latch byte g, latch lock bit g into lock_held, set o_Grant_Id=g, last_grant=g.
- Next state: LAUNCH.
REQ-016 IDLE with lock_held=1 SHALL consider only requester o_Grant_Id and wait indefinitely for its valid; other requesters get no ready.
REQ-017 The ready response SHALL be registered.
- Ready is asserted the cycle after valid is first seen in IDLE.
- Ready is a one-cycle pulse.
- At most one ready bit is high at any time.
REQ-018 LAUNCH SHALL drive o_Tx_DV=1 with o_Tx_Byte=latched byte for exactly one cycle, clear the watchdog counter, and go to WAIT_DONE.
REQ-019 WAIT_DONE SHALL:
- Go to DRAIN when i_Tx_Done=1.
- Otherwise increment a 16-bit watchdog counter.
- On reaching TIMEOUT_CLKS-1: pulse o_Timeout, clear lock_held, go to IDLE.
REQ-020 DRAIN SHALL stay while i_Tx_Done=1 and go to IDLE on the first cycle i_Tx_Done=0, so no launch coincides with a stale done.
REQ-021 o_Tx_DV SHALL be 0 outside LAUNCH; o_Tx_Byte SHALL hold its last value outside LAUNCH.
REQ-022 A requester dropping valid before ready SHALL cancel only that request; no byte is sent for it.
REQ-023 lock_held SHALL be cleared when a byte is accepted with i_Req_Lock[g]=0, and on timeout.
REQ-024 Changes to i_Req_Valid while the transmitter is busy SHALL not affect the current transfer.
REQ-025 Throughput: one byte per transmitter frame plus at most 4 clocks of arbitration overhead.

Reset
REQ-026 While i_Reset=1, the block SHALL hold:
- State IDLE.
- o_Req_Ready=0, o_Tx_DV=0, o_Tx_Byte=0x00, o_Grant_Id=0.
- o_Busy=0, o_Timeout=0.
- last_grant=3, so requester 0 has first priority.
- lock_held=0, watchdog=0.
REQ-027 Reset asserted mid-transfer SHALL abort immediately with no further o_Tx_DV.
- After release, arbitration restarts from requester 0.

Verification
REQ-028 Single requester: valid[2]=1, byte 0xA5 -> ready[2] pulse, DV pulse with byte 0xA5 one cycle later, grant=2, busy high until done clears.
REQ-029 Round-robin: valid=4'b1111 held through 4 transfers -> grant order 0,1,2,3; then 0 again.
REQ-030 Lock: requester 1 sends 0x10 (lock=1), 0x11 (lock=1), 0x12 (lock=0) while valid[0] is high -> three consecutive grants to 1, then 0.
REQ-031 Timeout: TIMEOUT_CLKS=20, i_Tx_Done held 0 -> o_Timeout pulse 20 cycles after DV, state IDLE, lock cleared.
REQ-032 Done stretch: i_Tx_Done high for 2 cycles with valid[3] pending -> next DV no earlier than 2 cycles after done falls.
REQ-033 Reset in WAIT_DONE: all outputs return to reset values asynchronously; with valid[3] pending after release -> first grant to 3, since only 3 is valid.
